// File: rtl/pattern_bank_pkg.sv
// Shared types and default geometry for the pattern bank and its buffer stores.
package pattern_bank_pkg;

    localparam int unsigned NO_BUFS_DEF   = 8;
    localparam int unsigned BUF_SIZE_DEF  = 22;
    localparam int unsigned BUF_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } load_state_e;

endpackage

// File: rtl/pattern_store.sv
// One pattern buffer: field and serial write ports (field wins on a same-byte
// collision), one combinational byte read and the whole buffer as a flat vector.
module pattern_store
    import pattern_bank_pkg::*;
#(
    parameter int unsigned BUF_SIZE  = BUF_SIZE_DEF,
    parameter int unsigned BUF_WIDTH = BUF_WIDTH_DEF,
    parameter int unsigned PTR_W     = $clog2(BUF_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fwe,
    input  logic [PTR_W-1:0]              fptr,
    input  logic [BUF_WIDTH-1:0]          fdata,
    input  logic                          swe,
    input  logic [PTR_W-1:0]              sptr,
    input  logic [BUF_WIDTH-1:0]          sdata,
    input  logic [PTR_W-1:0]              raddr,
    output logic [BUF_WIDTH-1:0]          rdata_c,
    output logic                          collide_c,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] flat
);

    logic [BUF_WIDTH-1:0] mem [BUF_SIZE];

    assign collide_c = fwe && swe && (fptr == sptr);
    assign rdata_c   = mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (fwe) begin
                mem[fptr] <= fdata;
            end
            if (swe && !collide_c) begin
                mem[sptr] <= sdata;
            end
        end
    end

    for (genvar i = 0; i < BUF_SIZE; i++) begin : g_flat
        assign flat[i*BUF_WIDTH +: BUF_WIDTH] = mem[i];
    end

endmodule

// File: rtl/pattern_bank.sv
// Bank of pattern buffers: serial scan loader, one-hot selected buffer output,
// random-access field port, sticky select-error and collision flags.
module pattern_bank
    import pattern_bank_pkg::*;
#(
    parameter int unsigned NO_BUFS   = NO_BUFS_DEF,
    parameter int unsigned BUF_SIZE  = BUF_SIZE_DEF,
    parameter int unsigned BUF_WIDTH = BUF_WIDTH_DEF,
    parameter int unsigned SEL_W     = $clog2(NO_BUFS),
    parameter int unsigned PTR_W     = $clog2(BUF_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sen,
    input  logic                          sin,
    input  logic [SEL_W-1:0]              saddr,
    output logic                          sout,
    output logic                          load_done,
    input  logic [NO_BUFS-1:0]            buffer_select,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] current_buffer,
    input  logic [NO_BUFS-1:0]            bufp,
    input  logic [PTR_W-1:0]              fieldp,
    input  logic [BUF_WIDTH-1:0]          field_in,
    input  logic                          field_write,
    output logic [BUF_WIDTH-1:0]          field_byte,
    output logic                          sel_error,
    output logic                          collide
);

    localparam int unsigned W      = BUF_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BUF_WIDTH);
    localparam int unsigned FLAT_W = BUF_SIZE * BUF_WIDTH;

    load_state_e          state_q, state_d;
    logic [SEL_W-1:0]     sbuf_q;
    logic [PTR_W-1:0]     ptr_q, ptr_next;
    logic [CNT_W-1:0]     bitcnt_q;
    logic [W-1:0]         asm_q, rb_q;
    logic [W-1:0]         serial_byte, idle_byte, next_byte;
    logic                 start, shift_en, byte_done, last_byte;

    logic [FLAT_W-1:0]    flat [NO_BUFS];
    logic [W-1:0]         rdata [NO_BUFS];
    logic [NO_BUFS-1:0]   collide_vec;
    logic [SEL_W-1:0]     bufp_idx, sel_idx;
    logic [PTR_W-1:0]     field_addr;
    logic                 bufp_ok, sel_ok, fieldp_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sen)  state_d = SHIFT;
            SHIFT:   if (!sen) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start     = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE:  start = sen;
            SHIFT: begin
                shift_en  = sen;
                byte_done = sen && (bitcnt_q == CNT_W'(W - 1));
            end
            default: ;
        endcase
    end

    assign last_byte   = (32'(ptr_q) == BUF_SIZE - 1);
    assign ptr_next    = last_byte ? '0 : ptr_q + PTR_W'(1);
    assign serial_byte = {asm_q[W-2:0], sin};

    // Readback sources: byte 0 of the addressed buffer while idle, next byte at a boundary.
    always_comb begin
        idle_byte = '0;
        if (32'(saddr) < NO_BUFS) begin
            idle_byte = flat[saddr][W-1:0];
        end
        next_byte = flat[sbuf_q][32'(ptr_next)*W +: W];
    end

    always_comb begin
        bufp_idx = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < NO_BUFS; i++) begin
            if (bufp[i])          bufp_idx = SEL_W'(i);
            if (buffer_select[i]) sel_idx  = SEL_W'(i);
        end
    end

    assign bufp_ok    = $onehot(bufp);
    assign sel_ok     = $onehot(buffer_select);
    assign fieldp_ok  = (32'(fieldp) < BUF_SIZE);
    assign field_addr = fieldp_ok ? fieldp : '0;

    for (genvar g = 0; g < NO_BUFS; g++) begin : g_store
        pattern_store #(
            .BUF_SIZE  (BUF_SIZE),
            .BUF_WIDTH (BUF_WIDTH),
            .PTR_W     (PTR_W)
        ) u_store (
            .clk       (clk),
            .rst_n     (rst_n),
            .fwe       (field_write && bufp_ok && fieldp_ok && bufp[g]),
            .fptr      (field_addr),
            .fdata     (field_in),
            .swe       (byte_done && (32'(sbuf_q) == g)),
            .sptr      (ptr_q),
            .sdata     (serial_byte),
            .raddr     (field_addr),
            .rdata_c   (rdata[g]),
            .collide_c (collide_vec[g]),
            .flat      (flat[g])
        );
    end

    // Loader datapath: first bit is consumed on the IDLE->SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf_q    <= '0;
            ptr_q     <= '0;
            bitcnt_q  <= '0;
            asm_q     <= '0;
            rb_q      <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= byte_done && last_byte;
            if (start) begin
                sbuf_q   <= saddr;
                ptr_q    <= '0;
                bitcnt_q <= CNT_W'(1);
                asm_q    <= serial_byte;
                rb_q     <= rb_q << 1;
            end else if (shift_en) begin
                asm_q <= serial_byte;
                if (byte_done) begin
                    ptr_q    <= ptr_next;
                    bitcnt_q <= '0;
                    rb_q     <= next_byte;
                end else begin
                    bitcnt_q <= bitcnt_q + CNT_W'(1);
                    rb_q     <= rb_q << 1;
                end
            end else if (state_q == IDLE) begin
                rb_q <= idle_byte;
            end
        end
    end

    assign sout = rb_q[W-1];

    // Field/selected-buffer outputs hold on invalid selects; flags are sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_byte     <= '0;
            current_buffer <= '0;
            sel_error      <= 1'b0;
            collide        <= 1'b0;
        end else begin
            if (bufp_ok) begin
                field_byte <= fieldp_ok ? rdata[bufp_idx] : '0;
            end
            if (sel_ok) begin
                current_buffer <= flat[sel_idx];
            end
            if (!bufp_ok || !fieldp_ok || !sel_ok) begin
                sel_error <= 1'b1;
            end
            if (|collide_vec) begin
                collide <= 1'b1;
            end
        end
    end

endmodule
